// File: rtl/servo_pkg.sv
// Shared defaults, slew direction type and width helpers for the servo bank.
package servo_pkg;

    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_CTR_W      = 20;
    localparam int unsigned DEF_PRESC      = 8;
    localparam int unsigned DEF_POS_W      = 8;
    localparam int unsigned DEF_MIN_OFFSET = 255;
    localparam int unsigned DEF_POS_MAX    = 255;
    localparam int unsigned DEF_CENTER     = 128;
    localparam int unsigned DEF_SLEW_STEP  = 0;

    typedef enum logic [1:0] {
        SLEW_HOLD = 2'd0,
        SLEW_UP   = 2'd1,
        SLEW_DOWN = 2'd2
    } slew_dir_e;

    // Index width for n items; never returns 0 so a single channel still has a port bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(n))) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Compare width: wide enough for both operands plus one bit so the offset add cannot wrap.
    function automatic int unsigned cmp_width(input int unsigned pos_w,
                                              input int unsigned ctr_w,
                                              input int unsigned presc);
        int unsigned fw;
        fw = ctr_w - presc;
        return ((pos_w > fw) ? pos_w : fw) + 1;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: shadow/active position, slew toward shadow at frame
// boundaries, pulse-width compare, frame-latched enable and output register.
module servo_channel
    import servo_pkg::*;
#(
    parameter int unsigned POS_W      = DEF_POS_W,
    parameter int unsigned CMP_W      = 13,
    parameter int unsigned MIN_OFFSET = DEF_MIN_OFFSET,
    parameter int unsigned POS_MAX    = DEF_POS_MAX,
    parameter int unsigned CENTER     = DEF_CENTER,
    parameter int unsigned SLEW_STEP  = DEF_SLEW_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [POS_W-1:0] wr_pos_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CMP_W-1:0] frame_pos_i,
    output logic             servo_o
);

    localparam logic [POS_W-1:0] POS_MAX_V = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] CENTER_V  = POS_W'(CENTER);
    localparam logic [POS_W-1:0] STEP_V    = POS_W'(SLEW_STEP);
    localparam logic [CMP_W-1:0] OFFSET_V  = CMP_W'(MIN_OFFSET);

    logic [POS_W-1:0] shadow_q, shadow_d;
    logic [POS_W-1:0] active_q, active_d;
    logic [POS_W-1:0] pos_clamped;
    logic [POS_W-1:0] diff;
    slew_dir_e        dir;
    logic             en_q;
    logic             servo_q;
    logic             cmp_hi;

    // Clamp the host position and select the next shadow value.
    always_comb begin
        pos_clamped = (wr_pos_i > POS_MAX_V) ? POS_MAX_V : wr_pos_i;
        shadow_d    = wr_en_i ? pos_clamped : shadow_q;
    end

    // Move active toward shadow on the load strobe, limited to SLEW_STEP when nonzero.
    always_comb begin
        dir      = SLEW_HOLD;
        diff     = '0;
        active_d = active_q;
        if (shadow_d > active_q) begin
            dir  = SLEW_UP;
            diff = shadow_d - active_q;
        end else if (shadow_d < active_q) begin
            dir  = SLEW_DOWN;
            diff = active_q - shadow_d;
        end
        if (load_i) begin
            case (dir)
                SLEW_UP:   active_d = ((SLEW_STEP == 0) || (diff <= STEP_V)) ? shadow_d : (active_q + STEP_V);
                SLEW_DOWN: active_d = ((SLEW_STEP == 0) || (diff <= STEP_V)) ? shadow_d : (active_q - STEP_V);
                default:   active_d = active_q;
            endcase
        end
    end

    assign cmp_hi = ({{(CMP_W-POS_W){1'b0}}, active_q} + OFFSET_V) > frame_pos_i;

    // Channel state; enable only changes with the position load so pulses are never cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= CENTER_V;
            active_q <= CENTER_V;
            en_q     <= 1'b0;
            servo_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            if (load_i) begin
                en_q <= en_i;
            end
            servo_q <= cmp_hi & en_q;
        end
    end

    assign servo_o = servo_q;

endmodule

// File: rtl/servo_bank.sv
// Bank of PWM servo channels sharing one free-running frame counter.
module servo_bank
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned CTR_W      = DEF_CTR_W,
    parameter int unsigned PRESC      = DEF_PRESC,
    parameter int unsigned POS_W      = DEF_POS_W,
    parameter int unsigned MIN_OFFSET = DEF_MIN_OFFSET,
    parameter int unsigned POS_MAX    = DEF_POS_MAX,
    parameter int unsigned CENTER     = DEF_CENTER,
    parameter int unsigned SLEW_STEP  = DEF_SLEW_STEP,
    localparam int unsigned CH_W      = clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [POS_W-1:0]  wr_pos,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] servo,
    output logic              frame_start
);

    localparam int unsigned FP_W  = CTR_W - PRESC;
    localparam int unsigned CMP_W = cmp_width(POS_W, CTR_W, PRESC);

    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
        $error("servo_bank: NUM_CH must be 1..16");
    end
    if (PRESC >= CTR_W) begin : g_bad_presc
        $error("servo_bank: PRESC must be smaller than CTR_W");
    end
    if ((MIN_OFFSET + POS_MAX) >= (64'd1 << FP_W)) begin : g_bad_range
        $error("servo_bank: MIN_OFFSET + POS_MAX must fit inside one frame");
    end
    if (CENTER > POS_MAX) begin : g_bad_center
        $error("servo_bank: CENTER exceeds POS_MAX");
    end
    if (SLEW_STEP > POS_MAX) begin : g_bad_slew
        $error("servo_bank: SLEW_STEP exceeds POS_MAX");
    end

    logic [CTR_W-1:0]  cnt_q, cnt_d;
    logic              frame_start_q;
    logic              load;
    logic [CMP_W-1:0]  frame_pos;
    logic [NUM_CH-1:0] wr_hit;

    assign cnt_d = cnt_q + 1'b1;

    // Active/enable load on the edge entering count 0, so the boundary cycle's
    // compare already sees the new frame's values; writes made during the
    // count-0 cycle therefore wait for the following boundary.
    assign load = (cnt_q == '1);

    assign frame_pos = {{(CMP_W-FP_W){1'b0}}, cnt_q[CTR_W-1:PRESC]};

    assign wr_ready = 1'b1;

    // Decode the write target; indices at or above NUM_CH match no channel.
    always_comb begin
        wr_hit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_valid && (wr_ch == CH_W'(i))) begin
                wr_hit[i] = 1'b1;
            end
        end
    end

    // Frame counter and frame-start marker aligned with the first output cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            frame_start_q <= (cnt_q == '0);
        end
    end

    assign frame_start = frame_start_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_channel #(
            .POS_W      (POS_W),
            .CMP_W      (CMP_W),
            .MIN_OFFSET (MIN_OFFSET),
            .POS_MAX    (POS_MAX),
            .CENTER     (CENTER),
            .SLEW_STEP  (SLEW_STEP)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .wr_en_i     (wr_hit[g]),
            .wr_pos_i    (wr_pos),
            .load_i      (load),
            .en_i        (ch_en[g]),
            .frame_pos_i (frame_pos),
            .servo_o     (servo[g])
        );
    end

endmodule

// File: doc/servo_bank.md
SERVO_BANK -- requirements
Module: servo_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent servo channels, range 1..16.
REQ-002 Parameter CTR_W, default 20: frame counter width; frame period is 2^CTR_W clk cycles.
REQ-003 Parameter PRESC, default 8: counter low bits ignored by the compare; one position unit equals 2^PRESC cycles.
REQ-004 Parameter POS_W, default 8: position width.
REQ-005 Parameter MIN_OFFSET, default 255: pulse-width floor, in position units.
REQ-006 Parameter POS_MAX, default 255: upper clamp applied to written positions.
REQ-007 Parameter CENTER, default 128: reset position for every channel.
REQ-008 Parameter SLEW_STEP, default 0: maximum position change per frame; 0 means an unlimited jump.
REQ-009 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 wr_valid  in  1  position write request.
REQ-012 wr_ready  out  1  write accepted when high together with wr_valid.
REQ-013 wr_ch  in  clog2(NUM_CH)  target channel index.
REQ-014 wr_pos  in  POS_W  requested position.
REQ-015 ch_en  in  NUM_CH  per-channel output enable.
REQ-016 servo  out  NUM_CH  registered PWM outputs.
REQ-017 frame_start  out  1  one-cycle pulse in the first cycle of each frame.

Function
REQ-018 A free-running CTR_W-bit counter SHALL increment every cycle and wrap from 2^CTR_W-1 to 0; the frame boundary is the cycle in which the counter equals 0.
REQ-019 Each channel SHALL hold a shadow register (written by the host) and an active register (used by the compare).
REQ-020 wr_ready SHALL be constant 1; an accepted write to a wr_ch >= NUM_CH SHALL be ignored.
REQ-021 An accepted write SHALL store min(wr_pos, POS_MAX) into the shadow register of wr_ch on the next clock edge.
REQ-022 At each frame boundary, active SHALL move toward shadow:
  - If SLEW_STEP = 0 or |shadow - active| <= SLEW_STEP, active SHALL become shadow.
  - Otherwise active SHALL change by exactly SLEW_STEP toward shadow.
REQ-023 A write coinciding with the boundary cycle SHALL NOT affect that boundary's load; it SHALL take effect at the next boundary.
REQ-024 ch_en SHALL be sampled into a latched enable only at frame boundaries, so no runt or truncated pulses are produced.
REQ-025 The compare for channel i SHALL be: high when (active_i + MIN_OFFSET) > counter[CTR_W-1:PRESC], evaluated at width max(POS_W, CTR_W-PRESC)+1 with no overflow.
REQ-026 servo[i] SHALL be registered, equal to (compare_i AND latched_en_i) of the previous cycle; total latency is 1 cycle.
REQ-027 The high time per frame SHALL be (active_i + MIN_OFFSET) * 2^PRESC cycles.
REQ-028 frame_start SHALL be registered and high in the cycle after the counter equals 0, aligned with the first servo output cycle of the frame.
REQ-029 Elaboration SHALL fail if MIN_OFFSET + POS_MAX >= 2^(CTR_W-PRESC), if CENTER > POS_MAX, or if SLEW_STEP > POS_MAX.

Reset
REQ-030 rst SHALL set: counter = 0; all shadow and active registers = CENTER; latched enables = 0; servo = 0; frame_start = 0.
REQ-031 rst asserted mid-frame SHALL drive servo low on the next edge and restart the frame from counter 0 after deassertion.
REQ-032 The first boundary after reset SHALL latch ch_en as normal.

Structure
REQ-033 Package servo_pkg SHALL hold the parameter defaults, the compare-width calculation function, and the clog2 helper.
REQ-034 Sub-module servo_channel SHALL contain one channel's shadow/active registers, slew logic, compare, enable latch and output register; servo_bank SHALL hold the counter and write decode, and instantiate NUM_CH copies.

Verification
Bench parameters: CTR_W=12, PRESC=4, POS_W=6, MIN_OFFSET=16, POS_MAX=50, CENTER=32, SLEW_STEP=8, NUM_CH=4.
REQ-035 Reset, then ch_en=4'hF -> frame 1 all servo low; frame 2 each channel high for 768 cycles, frame_start every 4096 cycles.
REQ-036 Write ch1=63 -> shadow clamped to 50; frames after 8,16,24,32-step sequence: 40,48,50 → widths 896, 1024, 1056 cycles.
REQ-037 Write ch2=0 in the counter==0 cycle -> that frame ch2 stays 32 (768 cycles); next frame 24 (640 cycles).
REQ-038 Deassert ch_en[3] mid-pulse -> current pulse completes full 768 cycles; next frame ch3 low throughout.
REQ-039 Assert rst at counter=300 while servo high -> servo 0 next cycle; after release, counter restarts at 0, outputs low for the first frame, registers = 32.
REQ-040 Write wr_ch=5 with value 10 -> no channel's shadow changes; widths unchanged.
